// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types for the pipeline hazard/forwarding logic:
//               operand-select encoding, per-stage destination tag and a
//               helper that tells whether a stage slot produces a register.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int REG_AW = 5;

    // Operand-select codes for the EX-stage forwarding muxes
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Destination-register bookkeeping carried alongside each pipeline stage
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_tag_t;

    // A slot produces register r when it is a real, writing instruction and r
    // is not the hardwired zero register.
    function automatic logic slot_writes(input stage_tag_t t, input logic [REG_AW-1:0] r);
        return t.valid & t.regwrite & (t.rd == r) & (r != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_stage_reg
// Description : One pipeline tag slot. Clears on reset, freezes on hold and
//               loads an empty (bubble) tag when asked to insert a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_stage_reg
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_hold,
    input  logic       i_bubble,
    input  stage_tag_t i_tag,
    output stage_tag_t o_tag
);

    stage_tag_t r_tag;

    // Slot register: reset beats hold, a bubble loads an all-zero tag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag <= '0;
        end else if (!i_hold) begin
            if (i_bubble) begin
                r_tag <= '0;
            end else begin
                r_tag <= i_tag;
            end
        end
    end

    assign o_tag = r_tag;

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_ctrl
// Description : Forwarding and load-use hazard controller for a five-stage
//               pipeline. Tracks EX/MEM/WB destination tags, registers the
//               EX operand-select codes and raises a combinational load-use
//               stall. A saturating counter records stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    output logic              stall_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    stage_tag_t        r_ex_tag;
    stage_tag_t        r_mem_tag;
    stage_tag_t        r_wb_tag;
    stage_tag_t        w_ex_in;
    logic              w_ex_in_valid;
    logic              w_ex_is_load;
    logic              w_load_use;
    fwd_sel_t          w_fwd_a_next;
    fwd_sel_t          w_fwd_b_next;
    fwd_sel_t          r_fwd_a;
    fwd_sel_t          r_fwd_b;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_unused;

    // Youngest producer wins; the WB slot is covered by register-file
    // write-through and is never a forwarding source.
    function automatic fwd_sel_t fwd_pick(input logic [REG_AW-1:0] rs,
                                          input stage_tag_t ex_tag,
                                          input stage_tag_t mem_tag);
        if (rs == '0)                   return FWD_RF;
        else if (slot_writes(ex_tag, rs))  return FWD_MEM;
        else if (slot_writes(mem_tag, rs)) return FWD_WB;
        else                            return FWD_RF;
    endfunction

    // Load-use detection against the load currently in EX
    always_comb begin
        w_ex_is_load = r_ex_tag.valid & r_ex_tag.memread & r_ex_tag.regwrite
                     & (r_ex_tag.rd != '0);
        w_load_use   = w_ex_is_load
                     & ((r_ex_tag.rd == id_rs1_i) | (r_ex_tag.rd == id_rs2_i));
    end

    // A squashed ID instruction is never a consumer, so flush masks the stall
    assign stall_o = id_valid_i & ~flush_i & w_load_use;

    // Tag for the instruction entering EX; flush or stall turn it into a bubble
    always_comb begin
        w_ex_in_valid    = id_valid_i & ~flush_i & ~stall_o;
        w_ex_in          = '0;
        w_ex_in.valid    = w_ex_in_valid;
        w_ex_in.rd       = id_rd_i;
        w_ex_in.regwrite = id_regwrite_i;
        w_ex_in.memread  = id_memread_i;
    end

    fwd_stage_reg u_ex_slot (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_hold   (hold_i),
        .i_bubble (~w_ex_in_valid),
        .i_tag    (w_ex_in),
        .o_tag    (r_ex_tag)
    );

    fwd_stage_reg u_mem_slot (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_hold   (hold_i),
        .i_bubble (1'b0),
        .i_tag    (r_ex_tag),
        .o_tag    (r_mem_tag)
    );

    fwd_stage_reg u_wb_slot (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_hold   (hold_i),
        .i_bubble (1'b0),
        .i_tag    (r_mem_tag),
        .o_tag    (r_wb_tag)
    );

    // Next operand selects from pre-edge slots; bubbles select the register file
    always_comb begin
        w_fwd_a_next = FWD_RF;
        w_fwd_b_next = FWD_RF;
        if (w_ex_in_valid) begin
            w_fwd_a_next = fwd_pick(id_rs1_i, r_ex_tag, r_mem_tag);
            w_fwd_b_next = fwd_pick(id_rs2_i, r_ex_tag, r_mem_tag);
        end
    end

    // Operand selects advance with the ID/EX register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (!hold_i) begin
            r_fwd_a <= w_fwd_a_next;
            r_fwd_b <= w_fwd_b_next;
        end
    end

    // Saturating count of advancing cycles spent stalled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (!hold_i && stall_o && (r_stall_cnt != C_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign fwd_a_o     = r_fwd_a;
    assign fwd_b_o     = r_fwd_b;
    assign stall_cnt_o = r_stall_cnt;

    // The WB slot and downstream load flags are tracked but not consumed here
    assign w_unused = &{1'b0, r_wb_tag, r_mem_tag.memread};

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_ctrl
// Description : Self-checking bench for fwd_hazard_ctrl. Directed scenarios
//               plus randomized traffic checked against an instruction-level
//               reference model (queue of instructions in EX/MEM/WB).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              hold_i;
    logic              flush_i;
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              stall_o;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .hold_i        (hold_i),
        .flush_i       (flush_i),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .stall_o       (stall_o),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } instr_t;

    instr_t pipe_q[$];   // [0] = in EX, [1] = in MEM, [2] = in WB
    int exp_fa, exp_fb, exp_cnt;
    int n_checks = 0;
    int n_errors = 0;

    function automatic int ref_sel(int rs);
        if (rs == 0) return 0;
        for (int age = 0; age < 2; age++)
            if (pipe_q[age].v && pipe_q[age].we && pipe_q[age].rd == rs)
                return (age == 0) ? 2 : 1;
        return 0;
    endfunction

    function automatic bit ref_stall(bit v, bit fl, int rs1, int rs2);
        instr_t p;
        p = pipe_q[0];
        return v && !fl && p.v && p.ld && p.we && p.rd != 0 && (p.rd == rs1 || p.rd == rs2);
    endfunction

    task automatic model_reset();
        instr_t b;
        b = '{0, 0, 0, 0};
        pipe_q.delete();
        repeat (3) pipe_q.push_back(b);
        exp_fa = 0; exp_fb = 0; exp_cnt = 0;
    endtask

    // One clock: drive at negedge, sample stall before the edge, return #1 after it
    task automatic step(input bit v, input int rs1, input int rs2, input int rd,
                        input bit we, input bit ld, input bit fl, input bit hd,
                        output bit st_obs, output bit st_exp);
        instr_t e;
        bit enter;
        @(negedge clk);
        id_valid_i = v; id_rs1_i = REG_AW'(rs1); id_rs2_i = REG_AW'(rs2);
        id_rd_i = REG_AW'(rd); id_regwrite_i = we; id_memread_i = ld;
        flush_i = fl; hold_i = hd;
        #1;
        st_obs = stall_o;
        st_exp = ref_stall(v, fl, rs1, rs2);
        if (!hd) begin
            enter  = v && !fl && !st_exp;
            exp_fa = enter ? ref_sel(rs1) : 0;
            exp_fb = enter ? ref_sel(rs2) : 0;
            e = '{enter, rd, we, ld};
            pipe_q.push_front(e);
            void'(pipe_q.pop_back());
            if (st_exp && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        bit a, b;
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, a, b);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst_i = 1; hold_i = 1; id_valid_i = 1; id_rs1_i = 5; id_rs2_i = 6;
        @(posedge clk); #1;
        rst_i = 0; hold_i = 0;
        model_reset();
        n_checks++;
        if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin n_errors++;
            $display("FAIL reset_fwd: got %b%b expected 0000", fwd_a_o, fwd_b_o); end
        n_checks++;
        if (stall_cnt_o !== '0) begin n_errors++;
            $display("FAIL reset_cnt: got %0d expected 0", stall_cnt_o); end
        n_checks++;
        if (stall_o !== 1'b0) begin n_errors++;
            $display("FAIL reset_stall: got %b expected 0", stall_o); end
    endtask

    task automatic test_mem_forward();
        bit so, se;
        nop(2);
        step(1, 1, 2, 5, 1, 0, 0, 0, so, se);          // add x5
        step(1, 5, 3, 10, 1, 0, 0, 0, so, se);         // sub rs1=x5
        n_checks++;
        if (so !== 1'b0) begin n_errors++;
            $display("FAIL mem_fwd_stall: got %b expected 0", so); end
        n_checks++;
        if ({fwd_a_o, fwd_b_o} !== 4'b1000) begin n_errors++;
            $display("FAIL mem_fwd_sel: got %b%b expected 1000", fwd_a_o, fwd_b_o); end
    endtask

    task automatic test_wb_forward();
        bit so, se;
        nop(2);
        step(1, 1, 2, 6, 1, 0, 0, 0, so, se);          // add x6
        step(1, 1, 2, 11, 1, 0, 0, 0, so, se);         // unrelated
        step(1, 3, 6, 12, 1, 0, 0, 0, so, se);         // or rs2=x6
        n_checks++;
        if ({fwd_a_o, fwd_b_o} !== 4'b0001) begin n_errors++;
            $display("FAIL wb_fwd_sel: got %b%b expected 0001", fwd_a_o, fwd_b_o); end
    endtask

    task automatic test_load_use();
        bit so, se;
        int c0;
        nop(2);
        c0 = exp_cnt;
        step(1, 0, 0, 7, 1, 1, 0, 0, so, se);          // lw x7
        step(1, 7, 2, 13, 1, 0, 0, 0, so, se);         // add rs1=x7 -> stall
        n_checks++;
        if (so !== 1'b1) begin n_errors++;
            $display("FAIL lu_stall_on: got %b expected 1", so); end
        n_checks++;
        if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin n_errors++;
            $display("FAIL lu_bubble_sel: got %b%b expected 0000", fwd_a_o, fwd_b_o); end
        n_checks++;
        if (stall_cnt_o !== CNT_W'(c0 + 1)) begin n_errors++;
            $display("FAIL lu_cnt: got %0d expected %0d", stall_cnt_o, c0 + 1); end
        step(1, 7, 2, 13, 1, 0, 0, 0, so, se);         // add retried
        n_checks++;
        if (so !== 1'b0) begin n_errors++;
            $display("FAIL lu_stall_off: got %b expected 0", so); end
        n_checks++;
        if ({fwd_a_o, fwd_b_o} !== 4'b0100) begin n_errors++;
            $display("FAIL lu_wb_sel: got %b%b expected 0100", fwd_a_o, fwd_b_o); end
        nop(1);
        n_checks++;
        if (stall_cnt_o !== CNT_W'(c0 + 1)) begin n_errors++;
            $display("FAIL lu_cnt_once: got %0d expected %0d", stall_cnt_o, c0 + 1); end
    endtask

    task automatic test_priority_x0();
        bit so, se;
        nop(2);
        step(1, 1, 2, 8, 1, 0, 0, 0, so, se);          // add x8
        step(1, 1, 2, 8, 1, 0, 0, 0, so, se);          // add x8
        step(1, 8, 0, 14, 1, 0, 0, 0, so, se);         // consumer rs1=x8
        n_checks++;
        if ({fwd_a_o, fwd_b_o} !== 4'b1000) begin n_errors++;
            $display("FAIL prio_sel: got %b%b expected 1000", fwd_a_o, fwd_b_o); end
        step(1, 1, 2, 0, 1, 0, 0, 0, so, se);          // writes x0
        step(1, 0, 0, 14, 1, 0, 0, 0, so, se);         // consumer of x0
        n_checks++;
        if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin n_errors++;
            $display("FAIL x0_sel: got %b%b expected 0000", fwd_a_o, fwd_b_o); end
        step(1, 1, 2, 0, 1, 1, 0, 0, so, se);          // lw x0
        step(1, 0, 0, 14, 1, 0, 0, 0, so, se);
        n_checks++;
        if (so !== 1'b0) begin n_errors++;
            $display("FAIL x0_stall: got %b expected 0", so); end
    endtask

    task automatic test_flush_over_stall();
        bit so, se;
        int c0;
        nop(2);
        c0 = exp_cnt;
        step(1, 0, 0, 9, 1, 1, 0, 0, so, se);          // lw x9
        step(1, 9, 0, 14, 1, 0, 1, 0, so, se);         // consumer, flushed
        n_checks++;
        if (so !== 1'b0) begin n_errors++;
            $display("FAIL flush_stall: got %b expected 0", so); end
        n_checks++;
        if ({fwd_a_o, fwd_b_o, stall_cnt_o} !== {4'b0000, CNT_W'(c0)}) begin n_errors++;
            $display("FAIL flush_bubble: got sel %b%b cnt %0d expected 0000 cnt %0d",
                     fwd_a_o, fwd_b_o, stall_cnt_o, c0); end
        step(1, 3, 9, 14, 1, 0, 0, 0, so, se);         // next consumer, load now in MEM
        n_checks++;
        if ({so, fwd_a_o, fwd_b_o} !== 5'b00001) begin n_errors++;
            $display("FAIL flush_after: got stall %b sel %b%b expected stall 0 sel 0001",
                     so, fwd_a_o, fwd_b_o); end
    endtask

    task automatic test_hold();
        bit so, se;
        int c0;
        nop(2);
        step(1, 1, 2, 3, 1, 0, 0, 0, so, se);          // add x3
        step(1, 3, 0, 7, 1, 1, 0, 0, so, se);          // lw x7 using x3
        c0 = exp_cnt;
        n_checks++;
        if ({fwd_a_o, fwd_b_o} !== 4'b1000) begin n_errors++;
            $display("FAIL hold_pre_sel: got %b%b expected 1000", fwd_a_o, fwd_b_o); end
        for (int i = 0; i < 3; i++) begin
            step(1, 7, 0, 15, 1, 0, 0, 1, so, se);     // frozen
            n_checks++;
            if ({so, fwd_a_o, fwd_b_o, stall_cnt_o} !== {5'b11000, CNT_W'(c0)}) begin n_errors++;
                $display("FAIL hold_frozen[%0d]: got stall %b sel %b%b cnt %0d expected stall 1 sel 1000 cnt %0d",
                         i, so, fwd_a_o, fwd_b_o, stall_cnt_o, c0); end
        end
        step(1, 7, 0, 15, 1, 0, 0, 0, so, se);         // released, stall completes
        n_checks++;
        if ({so, fwd_a_o, fwd_b_o, stall_cnt_o} !== {5'b10000, CNT_W'(c0 + 1)}) begin n_errors++;
            $display("FAIL hold_release: got stall %b sel %b%b cnt %0d expected stall 1 sel 0000 cnt %0d",
                     so, fwd_a_o, fwd_b_o, stall_cnt_o, c0 + 1); end
        step(1, 7, 0, 15, 1, 0, 0, 0, so, se);
        n_checks++;
        if ({so, fwd_a_o, fwd_b_o} !== 5'b00100) begin n_errors++;
            $display("FAIL hold_after: got stall %b sel %b%b expected stall 0 sel 0100",
                     so, fwd_a_o, fwd_b_o); end
    endtask

    task automatic test_reset_mid_stall();
        bit so, se;
        nop(2);
        step(1, 0, 0, 7, 1, 1, 0, 0, so, se);          // lw x7
        @(negedge clk);
        id_valid_i = 1; id_rs1_i = 7; id_rs2_i = 0; id_rd_i = 15;
        id_regwrite_i = 1; id_memread_i = 0; flush_i = 0; hold_i = 0;
        rst_i = 1;
        @(posedge clk); #1;
        rst_i = 0;
        model_reset();
        n_checks++;
        if ({stall_o, fwd_a_o, fwd_b_o, stall_cnt_o} !== {5'b00000, CNT_W'(0)}) begin n_errors++;
            $display("FAIL rst_mid_stall: got stall %b sel %b%b cnt %0d expected all 0",
                     stall_o, fwd_a_o, fwd_b_o, stall_cnt_o); end
    endtask

    task automatic test_random();
        bit so, se, v, we, ld, fl, hd;
        int rs1, rs2, rd;
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 9) < 8);
            rs1 = $urandom_range(0, 3);
            rs2 = $urandom_range(0, 3);
            rd  = $urandom_range(0, 3);
            we  = ($urandom_range(0, 9) < 8);
            ld  = ($urandom_range(0, 9) < 4);
            fl  = ($urandom_range(0, 9) == 0);
            hd  = ($urandom_range(0, 9) == 0);
            step(v, rs1, rs2, rd, we, ld, fl, hd, so, se);
            n_checks++;
            if (so !== se) begin n_errors++;
                $display("FAIL rnd_stall[%0d]: got %b expected %b", i, so, se); end
            n_checks++;
            if ({fwd_a_o, fwd_b_o} !== {2'(exp_fa), 2'(exp_fb)}) begin n_errors++;
                $display("FAIL rnd_sel[%0d]: got %b%b expected %b%b", i, fwd_a_o, fwd_b_o,
                         2'(exp_fa), 2'(exp_fb)); end
            n_checks++;
            if (stall_cnt_o !== CNT_W'(exp_cnt)) begin n_errors++;
                $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, stall_cnt_o, exp_cnt); end
        end
    endtask

    initial begin
        rst_i = 1; hold_i = 0; flush_i = 0; id_valid_i = 0;
        id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
        id_regwrite_i = 0; id_memread_i = 0;
        model_reset();
        test_reset();
        test_mem_forward();
        test_wb_forward();
        test_load_use();
        test_priority_x0();
        test_flush_over_stall();
        test_hold();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and load-use hazard controller for the five-stage pipeline. Tracks destination-register state of instructions in EX, MEM and WB. Produces registered 2-bit operand-select codes for the two EX-stage operand forwarding muxes, aligned with the instruction in EX. Raises a combinational stall that holds PC/IF-ID and injects a bubble into EX on a load-use hazard. Sits beside the ID/EX pipeline register and advances with it.

## Interface
- `REG_AW`, 5, register-address width
- `CNT_W`, 16, width of the stall performance counter
- `clk_i` in 1: clock
- `rst_i` in 1: synchronous, active-high reset
- `hold_i` in 1: global freeze (e.g. memory wait); no internal state changes
- `flush_i` in 1: ID instruction is squashed (taken branch); it enters EX as a bubble
- `id_valid_i` in 1: ID holds a real instruction
- `id_rs1_i`, `id_rs2_i` in REG_AW: ID source registers
- `id_rd_i` in REG_AW: ID destination register
- `id_regwrite_i` in 1: ID instruction writes `rd`
- `id_memread_i` in 1: ID instruction is a load
- `stall_o` out 1: combinational load-use stall; hold PC and IF/ID, bubble into EX
- `fwd_a_o`, `fwd_b_o` out 2: registered operand selects for the EX instruction
  - 00 = register-file data
  - 01 = WB write data
  - 10 = MEM ALU result
  - 11 never driven
- `stall_cnt_o` out CNT_W: saturating count of stall cycles

## Operation
- **Internal tracking:** three stage slots (EX, MEM, WB). Each holds `valid`, `rd`, `regwrite`; EX additionally holds `memread`.
- **A slot "writes r"** when `valid & regwrite & rd == r & r != 0`.
- **Load-use stall:**
  - `stall_o = id_valid_i & ~flush_i & EX.valid & EX.memread & EX.regwrite & EX.rd != 0`, and `EX.rd` matches `id_rs1_i` or `id_rs2_i`.
  - `stall_o` is computed regardless of `hold_i`.
- **Advance** on every edge with `hold_i = 0`:
  - WB ← MEM
  - MEM ← EX
  - EX ← ID, with `EX.valid = id_valid_i & ~flush_i & ~stall_o`. This is the bubble on flush or stall.
- **Forward select** for an instruction entering EX, per operand `rs`, computed from the pre-edge slots:
  - `rs == 0` → 00
  - else if EX slot writes `rs` (becomes MEM) → 10
  - else if MEM slot writes `rs` (becomes WB) → 01
  - else 00
  - When the instruction entering EX is a bubble, both selects load 00.
- **WB-to-ID hazard:** same-cycle register-file write-through covers it; the block never forwards from the current WB slot.
- **`stall_cnt_o`:** increments on each advancing edge where `stall_o = 1`, and saturates at all-ones.

## Timing
- **Reset** (edge with `rst_i = 1`, takes priority over `hold_i`):
  - all slot `valid` = 0
  - `fwd_a_o = fwd_b_o = 00`
  - `stall_cnt_o = 0`
  - `stall_o` therefore 0 until a load enters EX
- **Selects:** `fwd_*_o` change one edge after ID inputs are sampled, and are valid for the whole cycle the instruction spends in EX.
- **Stall length:** exactly one cycle per load-use. On the next cycle the load is in MEM; the consumer, still in ID, is then forwarded 01 (from WB) when it enters EX.
- **`hold_i = 1`:** slots, `fwd_*_o` and counter all frozen.
- **`flush_i` and stall in the same cycle:** flush wins. `stall_o = 0`, bubble enters EX, counter unchanged.
- **EX and MEM both write `rs`:** 10 (youngest producer) wins.
- **Bubbles, `regwrite = 0` slots and `rd = 0`** never trigger forwarding or stall.
- **Reset mid-stall:** all tracking is discarded; the pipeline restarts bubble-filled.

## Structure
- **Shared package `pipe_pkg`:**
  - `fwd_sel_t` enum with `FWD_RF = 2'b00`, `FWD_WB = 2'b01`, `FWD_MEM = 2'b10`
  - `REG_AW` constant
  - `stage_tag_t` struct {`valid`, `rd`, `regwrite`, `memread`}
- **Sub-module `fwd_stage_reg`:** one tag slot with reset, hold and bubble-insert. Instantiated three times.
- **In `fwd_hazard_ctrl` itself:** compare logic and counter.

## Test plan
- **MEM forward:** `add x5` (regwrite), then `sub` with rs1 = 5 next cycle → `sub` in EX sees `fwd_a_o = 10`, `fwd_b_o = 00`; `stall_o` never 1.
- **WB forward:** `add x6`, unrelated instruction, then `or` with rs2 = 6 → `fwd_b_o = 01` in `or`'s EX cycle.
- **Load-use:** `lw x7`, then `add` with rs1 = 7:
  - `stall_o = 1` for exactly one cycle
  - EX gets a bubble (selects 00)
  - `add` then enters EX with `fwd_a_o = 01`
  - `stall_cnt_o` increments 0 → 1
- **Priority and x0:** `add x8`, `add x8`, then consumer with rs1 = 8 → 10. Producer writing x0, consumer with rs1 = 0 → 00.
- **Flush over stall:** `lw x9`, consumer rs1 = 9 with `flush_i = 1` → `stall_o = 0`, bubble enters EX, counter unchanged.
- **Hold and reset:**
  - `hold_i = 1` for 3 cycles mid load-use → outputs and counter frozen; the stall completes after release.
  - `rst_i = 1` mid-stall → next cycle `stall_o = 0`, selects 00, counter 0.
